alu_cmd_driver: RTL and testbench

Initiator side of the tiny 4-bit ALU pin interface. Accepts command words over a valid/ready stream, buffers them in a small FIFO, and drives operands and opcode onto the ALU's `ui_in`/`uio_in` pins. After a fixed settle time it samples the ALU's `uo_out` and returns result and flags on a valid/ready response stream. It sits between an on-chip host or sequencer and the ALU, replacing the hand-timed stimulus used today.

---
 rtl/alu_cmd_driver.sv | 231 +++++++++++++++++++++++
 tb/tb_alu_cmd_driver.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_driver.sv
// ---------------------------------------------------------------------------
// alu_cmd_driver
//
// Initiator for the 4-bit ALU pin interface. Command words arrive on a
// valid/ready stream and are buffered in a small FIFO. One command at a time
// is driven onto the ALU pins. After SETTLE_CYCLES edges the ALU output is
// sampled and returned, with the opcode echoed, on a valid/ready response
// stream.
//
// Optional feature (macro ALU_DRV_CHECK_EN): compares the sampled result with
// the expected value carried in the command, flags mismatches in rsp_data[12],
// and maintains the sticky err flag and the saturating err_count. When the
// macro is undefined these outputs are constant 0.
//
// Parameters:
//   SETTLE_CYCLES  edges between driving the pins and sampling alu_uo (2..255)
//   CMD_DEPTH      command FIFO entries (power of 2, >= 2)
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   cmd_valid/ready command handshake; cmd_ready = !fifo_full
//   cmd_data[15:0]  {expected, opcode, B, A}
//   alu_ui[7:0]     {B, A} to ALU ui_in
//   alu_uio[7:0]    {4'b0, opcode} to ALU uio_in
//   alu_uo[7:0]     ALU uo_out: {Z, N, V, C, result}
//   rsp_valid/ready response handshake
//   rsp_data[12:0]  {mismatch, opcode, alu_uo}
//   busy            FSM not idle or FIFO not empty
//   err             sticky mismatch flag
//   err_count[7:0]  saturating mismatch count
// ---------------------------------------------------------------------------
module alu_cmd_driver #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CMD_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_data,
    output logic [7:0]  alu_ui,
    output logic [7:0]  alu_uio,
    input  logic [7:0]  alu_uo,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [12:0] rsp_data,
    output logic        busy,
    output logic        err,
    output logic [7:0]  err_count
);

    localparam int AW = $clog2(CMD_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state, state_next;

`ifdef ALU_DRV_CHECK_EN
    function automatic logic cmp_mismatch(input logic [3:0] res,
                                          input logic [3:0] expv,
                                          input logic [3:0] op);
        // REG_WRITE results are not meaningful to compare.
        return (op != 4'h8) && (res != expv);
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction
`endif

    // Command FIFO: pointers carry one extra wrap bit to tell full from empty.
    logic [15:0]   mem [CMD_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          full, empty, push, pop;
    logic [15:0]   head;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign head  = mem[rd_ptr[AW-1:0]];

    // Acceptance depends only on full, never on a same-edge pop.
    assign push  = cmd_valid && !full;

    logic issue, capture, release_rsp;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= cmd_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    logic [7:0] cnt;

    // FSM next-state and strobes
    always_comb begin
        state_next  = state;
        issue       = 1'b0;
        capture     = 1'b0;
        release_rsp = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    issue      = 1'b1;
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt == 8'd0) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    release_rsp = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign pop = issue;

    // Stage p0: issue -- pins driven from the popped word, settle count loaded
    logic [7:0] ui_p0, uio_p0;
`ifdef ALU_DRV_CHECK_EN
    logic [3:0] exp_p0;
`else
    logic       unused_head_hi;
    assign unused_head_hi = ^head[15:12];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ui_p0  <= '0;
            uio_p0 <= '0;
            cnt    <= '0;
`ifdef ALU_DRV_CHECK_EN
            exp_p0 <= '0;
`endif
        end else if (issue) begin
            ui_p0  <= head[7:0];
            uio_p0 <= {4'b0000, head[11:8]};
            cnt    <= CNT_LOAD;
`ifdef ALU_DRV_CHECK_EN
            exp_p0 <= head[15:12];
`endif
        end else if ((state == SETTLE) && (cnt != 8'd0)) begin
            cnt <= cnt - 8'd1;
        end
    end

    // Stage p1: capture -- sampled result, opcode echo and mismatch
    logic [12:0] rsp_p1;
    logic        vld_p1;
    logic        mis;

`ifdef ALU_DRV_CHECK_EN
    assign mis = cmp_mismatch(alu_uo[3:0], exp_p0, uio_p0[3:0]);
`else
    assign mis = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_p1 <= '0;
            vld_p1 <= 1'b0;
        end else if (capture) begin
            rsp_p1 <= {mis, uio_p0[3:0], alu_uo};
            vld_p1 <= 1'b1;
        end else if (release_rsp) begin
            vld_p1 <= 1'b0;
        end
    end

`ifdef ALU_DRV_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err       <= 1'b0;
            err_count <= '0;
        end else if (capture && mis) begin
            err       <= 1'b1;
            err_count <= sat_inc8(err_count);
        end
    end
`else
    assign err       = 1'b0;
    assign err_count = '0;
`endif

    assign cmd_ready = !full;
    assign alu_ui    = ui_p0;
    assign alu_uio   = uio_p0;
    assign rsp_valid = vld_p1;
    assign rsp_data  = rsp_p1;
    assign busy      = (state != IDLE) || !empty;

endmodule

// File: tb/tb_alu_cmd_driver.sv
module tb_alu_cmd_driver;

    localparam int S1 = 4;
`ifdef ALU_DRV_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk, rst;
    logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, busy, err;
    logic [15:0] cmd_data;
    logic [7:0]  alu_ui, alu_uio, alu_uo, err_count;
    logic [12:0] rsp_data;

    logic        cmd_valid2, cmd_ready2, rsp_valid2, rsp_ready2, busy2, err2;
    logic [15:0] cmd_data2;
    logic [7:0]  alu_ui2, alu_uio2, alu_uo2, err_count2;
    logic [12:0] rsp_data2;

    alu_cmd_driver #(.SETTLE_CYCLES(S1), .CMD_DEPTH(4)) u_dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_data(cmd_data), .alu_ui(alu_ui), .alu_uio(alu_uio), .alu_uo(alu_uo),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .busy(busy), .err(err), .err_count(err_count)
    );

    alu_cmd_driver #(.SETTLE_CYCLES(2), .CMD_DEPTH(4)) u_dut2 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
        .cmd_data(cmd_data2), .alu_ui(alu_ui2), .alu_uio(alu_uio2), .alu_uo(alu_uo2),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_data(rsp_data2),
        .busy(busy2), .err(err2), .err_count(err_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // ALU behaviour: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 ADD_REG (A + reg[B[1:0]]),
    // 6 NOT A, 7 PASS_B, 8 REG_WRITE (reg[B[1:0]] = A, result A), else PASS_A.
    function automatic logic [7:0] alu_eval(input logic [3:0] a, input logic [3:0] b,
                                            input logic [3:0] op, input logic [3:0][3:0] regs);
        logic [4:0] s;
        logic [3:0] res, bb;
        logic       v, c;
        s = '0; v = 1'b0; c = 1'b0; res = a; bb = b;
        case (op)
            4'h0, 4'h5: begin
                if (op == 4'h5) bb = regs[b[1:0]];
                s   = {1'b0, a} + {1'b0, bb};
                res = s[3:0];
                c   = s[4];
                v   = (a[3] == bb[3]) && (res[3] != a[3]);
            end
            4'h1: begin
                s   = {1'b0, a} - {1'b0, b};
                res = s[3:0];
                c   = s[4];
                v   = (a[3] != b[3]) && (res[3] != a[3]);
            end
            4'h2: res = a & b;
            4'h3: res = a | b;
            4'h4: res = a ^ b;
            4'h6: res = ~a;
            4'h7: res = b;
            default: res = a;
        endcase
        return {(res == 4'h0), res[3], v, c, res};
    endfunction

    // ALU attached to the main DUT's pins.
    logic [3:0][3:0] alu_regs;
    logic            alu_clr;
    assign alu_uo = alu_eval(alu_ui[3:0], alu_ui[7:4], alu_uio[3:0], alu_regs);
    always @(posedge clk or posedge alu_clr) begin
        if (alu_clr) alu_regs <= '0;
        else if (alu_uio[3:0] == 4'h8) alu_regs[alu_ui[5:4]] <= alu_ui[3:0];
    end

    // Second DUT sees a pass-B ALU.
    assign alu_uo2 = {4'h0, alu_ui2[7:4]};

    // Reference model state
    logic [3:0][3:0] ref_regs;
    logic [12:0]     sb_q[$];
    int              pops = 0;
    logic            exp_err = 1'b0;
    int              exp_cnt = 0;

    task automatic model_cmd(input logic [15:0] c, output logic [12:0] r);
        logic [7:0] o;
        logic       m;
        o = alu_eval(c[3:0], c[7:4], c[11:8], ref_regs);
        if (c[11:8] == 4'h8) ref_regs[c[5:4]] = c[3:0];
        m = CHK && (c[11:8] != 4'h8) && (o[3:0] != c[15:12]);
        r = {m, c[11:8], o};
    endtask

    task automatic note_mis(input logic m);
        if (m) begin
            exp_err = 1'b1;
            if (exp_cnt < 255) exp_cnt++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic cv, input logic [15:0] cd, input logic rr, output logic acc);
        logic [12:0] e;
        cmd_valid = cv;
        cmd_data  = cd;
        rsp_ready = rr;
        acc = cv && cmd_ready;
        if (acc) begin
            model_cmd(cd, e);
            sb_q.push_back(e);
        end
        if (rsp_valid && rr) begin
            if (sb_q.size() == 0) begin
                fail_now("rsp_unexpected");
            end else begin
                e = sb_q.pop_front();
                chk("rsp_data_order", 32'(rsp_data), 32'(e));
                note_mis(e[12]);
                pops++;
            end
        end
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_alu_ui"}, 32'(alu_ui), 32'h0);
        chk({tag, "_alu_uio"}, 32'(alu_uio), 32'h0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
        chk({tag, "_rsp_data"}, 32'(rsp_data), 32'h0);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'h1);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_err"}, 32'(err), 32'h0);
        chk({tag, "_err_count"}, 32'(err_count), 32'h0);
    endtask

    typedef struct {
        logic [15:0] cmd;
        logic [7:0]  ui;
        logic [7:0]  uio;
        logic [3:0]  res;
        logic        mis;   // mismatch when the check is enabled
    } vec_t;

    task automatic run_single(input vec_t v);
        logic [12:0] e;
        logic        early;
        logic        m;
        cmd_valid = 1'b1;
        cmd_data  = v.cmd;
        rsp_ready = 1'b0;
        chk("single_cmd_ready", 32'(cmd_ready), 32'h1);
        tick();                               // accept edge E
        cmd_valid = 1'b0;
        tick();                               // E+1: pins driven
        chk("single_alu_ui", 32'(alu_ui), 32'(v.ui));
        chk("single_alu_uio", 32'(alu_uio), 32'(v.uio));
        early = rsp_valid;
        for (int k = 2; k <= S1; k++) begin
            tick();
            early = early | rsp_valid;
        end
        chk("single_rsp_early", 32'(early), 32'h0);
        tick();                               // E+1+S1
        chk("single_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("single_res", 32'(rsp_data[3:0]), 32'(v.res));
        chk("single_op_echo", 32'(rsp_data[11:8]), 32'(v.cmd[11:8]));
        m = CHK ? v.mis : 1'b0;
        chk("single_mismatch", 32'(rsp_data[12]), 32'(m));
        model_cmd(v.cmd, e);
        chk("single_model", 32'(rsp_data), 32'(e));
        note_mis(m);
        chk("single_err", 32'(err), 32'(exp_err));
        chk("single_err_count", 32'(err_count), 32'(exp_cnt));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("single_rsp_clear", 32'(rsp_valid), 32'h0);
        chk("single_busy_idle", 32'(busy), 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[11];
        vec_t        v;
        logic        acc, acc6, saw;
        logic [15:0] bp[6];
        int          p0;

        vecs[0]  = '{16'h0838, 8'h38, 8'h08, 4'h8, 1'b0};  // REG_WRITE r3=8
        vecs[1]  = '{16'h0837, 8'h37, 8'h08, 4'h7, 1'b0};  // REG_WRITE r3=7
        vecs[2]  = '{16'h9532, 8'h32, 8'h05, 4'h9, 1'b0};  // ADD_REG 2+r3
        vecs[3]  = '{16'h9053, 8'h53, 8'h00, 4'h8, 1'b1};  // ADD 3+5, exp 9
        vecs[4]  = '{16'h0791, 8'h91, 8'h07, 4'h9, 1'b1};  // PASS_B, exp 0
        vecs[5]  = '{16'hE175, 8'h75, 8'h01, 4'hE, 1'b0};  // SUB 5-7
        vecs[6]  = '{16'h82AC, 8'hAC, 8'h02, 4'h8, 1'b0};  // AND
        vecs[7]  = '{16'h04FF, 8'hFF, 8'h04, 4'h0, 1'b0};  // XOR
        vecs[8]  = '{16'hF80A, 8'h0A, 8'h08, 4'hA, 1'b0};  // REG_WRITE never flags
        vecs[9]  = '{16'h001F, 8'h1F, 8'h00, 4'h0, 1'b0};  // ADD wrap
        vecs[10] = '{16'hB501, 8'h01, 8'h05, 4'hB, 1'b0};  // ADD_REG 1+r0

        bp[0] = 16'h0012; bp[1] = 16'h3123; bp[2] = 16'h0234;
        bp[3] = 16'h7345; bp[4] = 16'h0756; bp[5] = 16'h5567;

        ref_regs   = '0;
        cmd_valid  = 1'b0; cmd_data  = '0; rsp_ready  = 1'b0;
        cmd_valid2 = 1'b0; cmd_data2 = '0; rsp_ready2 = 1'b0;
        rst = 1'b0; alu_clr = 1'b0;
        #1;
        rst = 1'b1; alu_clr = 1'b1;
        #1;
        alu_clr = 1'b0;
        check_reset_outputs("por");
        chk("por_rsp_valid2", 32'(rsp_valid2), 32'h0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Directed vectors
        for (int i = 0; i < 11; i++) begin
            v = vecs[i];
            run_single(v);
        end
        chk("table_err_count", 32'(err_count), CHK ? 32'd2 : 32'd0);

        // Reset during SETTLE with one command queued
        cmd_valid = 1'b1; cmd_data = 16'h0012;
        tick();
        cmd_data = 16'h0034;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("mid_busy", 32'(busy), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        tick();
        rst = 1'b0;
        exp_err = 1'b0;
        exp_cnt = 0;
        saw = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            saw = saw | rsp_valid | busy;
        end
        chk("mid_no_rsp", 32'(saw), 32'h0);
        v = '{16'h0791, 8'h91, 8'h07, 4'h9, 1'b1};
        run_single(v);

        // SETTLE_CYCLES=2 latency
        cmd_valid2 = 1'b1; cmd_data2 = 16'h0791;
        tick();
        cmd_valid2 = 1'b0;
        tick();
        chk("s2_ui", 32'(alu_ui2), 32'h91);
        chk("s2_uio", 32'(alu_uio2), 32'h07);
        chk("s2_rsp_e1", 32'(rsp_valid2), 32'h0);
        tick();
        chk("s2_rsp_e2", 32'(rsp_valid2), 32'h0);
        tick();
        chk("s2_rsp_e3", 32'(rsp_valid2), 32'h1);
        chk("s2_rsp_data", 32'(rsp_data2), 32'({CHK, 4'h7, 8'h09}));
        rsp_ready2 = 1'b1;
        tick();
        rsp_ready2 = 1'b0;
        chk("s2_rsp_clear", 32'(rsp_valid2), 32'h0);
        chk("s2_busy", 32'(busy2), 32'h0);
        chk("s2_err", 32'(err2), 32'(CHK));
        chk("s2_err_count", 32'(err_count2), 32'(CHK));

        // Backpressure: 1 in flight + 4 buffered, 6th refused
        p0 = pops;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, bp[i], 1'b0, acc);
            chk("bp_accept", 32'(acc), 32'h1);
        end
        chk("bp_full_ready", 32'(cmd_ready), 32'h0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, bp[5], 1'b0, acc);
            chk("bp_6th_blocked", 32'(acc), 32'h0);
        end
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold_valid", 32'(rsp_valid), 32'h1);
            chk("bp_hold_data", 32'(rsp_data), 32'(sb_q[0]));
            step(1'b1, bp[5], 1'b0, acc);
        end
        acc6 = 1'b0;
        for (int i = 0; i < 80 && (pops - p0) < 6; i++) begin
            step(!acc6, bp[5], 1'b1, acc);
            if (acc) acc6 = 1'b1;
        end
        chk("bp_6th_accepted", 32'(acc6), 32'h1);
        chk("bp_resp_count", 32'(pops - p0), 32'd6);
        chk("bp_err_count", 32'(err_count), 32'(exp_cnt));

        // Randomized traffic against the scoreboard
        p0 = pops;
        for (int i = 0; i < 6000 && (pops - p0) < 320; i++) begin
            step(($urandom % 3) != 0, 16'($urandom), ($urandom % 4) != 0, acc);
        end
        for (int i = 0; i < 200 && (sb_q.size() != 0 || busy); i++) begin
            step(1'b0, 16'h0000, 1'b1, acc);
        end
        chk("rand_drained", 32'(sb_q.size()), 32'd0);
        chk("rand_busy", 32'(busy), 32'h0);
        chk("rand_err", 32'(err), 32'(exp_err));
        chk("rand_err_count", 32'(err_count), 32'(exp_cnt));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
